// File: rtl/mult_ctrl.sv
// Sequencer for the 8-bit add/shift multiplier: one clear phase, then NUM_BITS add/shift iterations.
// Optional macro MULT_CTRL_SKIP_ADD_EN skips ADD cycles whose multiplier bit is zero.
module mult_ctrl #(
  parameter  int NUM_BITS = 8,
  localparam int CW       = $clog2(NUM_BITS)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          ClearA_LoadB,
  input  logic          M,
  output logic          Clr_Ld,
  output logic          ClearA,
  output logic          Add,
  output logic          Sub,
  output logic          Shift,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Step
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST_STEP = CW'(NUM_BITS - 1);

  state_t        state_q;
  logic [CW-1:0] step_q;
  logic          run_q;
  logic          start;
  logic          last;
  logic          active;

  assign start  = Run & ~run_q;
  assign last   = (step_q == LAST_STEP);
  assign active = ~Reset;

  // run_q resets high so a Run held through reset is not mistaken for a start
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      run_q   <= 1'b1;
    end else begin
      run_q <= Run;
      unique case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_CLR;
        end
        S_CLR: begin
          step_q <= '0;
`ifdef MULT_CTRL_SKIP_ADD_EN
          state_q <= M ? S_ADD : S_SHIFT;
`else
          state_q <= S_ADD;
`endif
        end
        S_ADD: begin
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          // exit on the last iteration before any increment, so Step never wraps
          if (last) begin
            state_q <= S_DONE;
          end else begin
            step_q <= step_q + CW'(1);
`ifdef MULT_CTRL_SKIP_ADD_EN
            state_q <= M ? S_ADD : S_SHIFT;
`else
            state_q <= S_ADD;
`endif
          end
        end
        S_DONE: begin
          if (!Run) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state; Reset forces them low in the same cycle
  assign ClearA = active & (state_q == S_CLR);
  assign Add    = active & (state_q == S_ADD) & M & ~last;
  assign Sub    = active & (state_q == S_ADD) & M & last;
  assign Shift  = active & (state_q == S_SHIFT);
  assign Busy   = active & ((state_q == S_CLR) | (state_q == S_ADD) | (state_q == S_SHIFT));
  assign Done   = active & (state_q == S_DONE);
  assign Clr_Ld = active & ClearA_LoadB & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign Step   = step_q;

endmodule

// File: tb/tb_mult_ctrl.sv
// Scoreboard bench for mult_ctrl: a small B-register model feeds M, expected strobes are queued per multiply.
module tb_mult_ctrl;
  localparam int N  = 8;
  localparam int CW = $clog2(N);
`ifdef MULT_CTRL_SKIP_ADD_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Reset, Run, ClearA_LoadB, M;
  logic          Clr_Ld, ClearA, Add, Sub, Shift, Busy, Done;
  logic [CW-1:0] Step;
  logic [N-1:0]  sw = '0;
  logic [N-1:0]  Bq = '0;

  mult_ctrl #(.NUM_BITS(N)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_Ld(Clr_Ld), .ClearA(ClearA), .Add(Add), .Sub(Sub), .Shift(Shift),
    .Busy(Busy), .Done(Done), .Step(Step)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // B register of the datapath; the upper bit refills with whatever A shifts in
  always @(posedge Clk) begin
    if (Clr_Ld) Bq <= sw;
    else if (Shift) Bq <= {1'($urandom_range(0, 1)), Bq[N-1:1]};
  end

`ifdef MULT_CTRL_SKIP_ADD_EN
  assign M = Shift ? Bq[1] : Bq[0];
`else
  assign M = Bq[0];
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic clra, add, sub, shf;
    int   step;
    bit   chk_step;
  } rec_t;

  rec_t exp_q[$];
  int   done_q[$];

  // Monitor: one record per Busy cycle, plus the DONE entry cycle
  logic done_prev = 1'b0;
  rec_t e;
  always @(negedge Clk) begin
    #2;
    if (!Reset && Busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_busy", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("clearA", ClearA, e.clra);
        chk("add", Add, e.add);
        chk("sub", Sub, e.sub);
        chk("shift", Shift, e.shf);
        chk("clr_ld_busy", Clr_Ld, 0);
        if (e.chk_step) chk("step", Step, e.step);
      end
    end
    if (!Reset && Done && !done_prev) begin
      if (done_q.size() == 0) chk("unexpected_done", 1, 0);
      else chk("done_edge", cyc, done_q.pop_front());
    end
    done_prev = Done && !Reset;
  end

  task automatic run_mult(input logic [N-1:0] b, input bit toggle, input bit abort, input bit prio);
    rec_t r;
    int   k, lat;
    bit   seen_done;
    @(negedge Clk);
    sw = b;
    ClearA_LoadB = 1'b1;
    if (!prio) begin
      #1 chk("clr_ld_idle", Clr_Ld, 1);
      @(negedge Clk);
      ClearA_LoadB = 1'b0;
    end
    // Reference: clear, then per bit an optional ADD cycle and a SHIFT cycle
    r.clra = 1; r.add = 0; r.sub = 0; r.shf = 0; r.step = 0; r.chk_step = 0;
    exp_q.push_back(r);
    for (int i = 0; i < N; i++) begin
      if (!SKIP || b[i]) begin
        r.clra = 0; r.add = b[i] && (i < N-1); r.sub = b[i] && (i == N-1);
        r.shf = 0; r.step = i; r.chk_step = 1;
        exp_q.push_back(r);
      end
      r.clra = 0; r.add = 0; r.sub = 0; r.shf = 1; r.step = i; r.chk_step = 1;
      exp_q.push_back(r);
    end
    lat = SKIP ? (1 + N + $countones(b)) : (1 + 2*N);
    k = cyc + 1;
    done_q.push_back(k + lat);
    Run = 1'b1;
    if (prio) #1 chk("clr_ld_prio", Clr_Ld, 1);

    seen_done = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge Clk);
      if (abort && Busy && Step == 3) begin
        Reset = 1'b1;
        #1 chk("abort_outputs", {ClearA, Add, Sub, Shift, Busy, Done, Clr_Ld}, 0);
        @(negedge Clk);
        Reset = 1'b0;
        Run = 1'b0;
        exp_q.delete();
        done_q.delete();
        #1 chk("abort_busy", Busy, 0);
        chk("abort_step", Step, 0);
        return;
      end
      ClearA_LoadB = Busy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (toggle && c == 3) Run = 1'b0;
      if (toggle && c == 4) Run = 1'b1;
      if (Done) begin
        seen_done = 1;
        break;
      end
    end
    ClearA_LoadB = 1'b0;
    if (!seen_done) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
      done_q.delete();
    end

    // Run held: controller must sit in DONE
    for (int h = 0; h < 3; h++) begin
      @(negedge Clk);
      #1 chk("done_hold", Done, 1);
      chk("busy_in_done", Busy, 0);
      if (h == 1) begin
        ClearA_LoadB = 1'b1;
        #1 chk("clr_ld_done", Clr_Ld, 1);
        ClearA_LoadB = 1'b0;
      end
    end
    Run = 1'b0;
    @(negedge Clk);
    #1 chk("idle_done", Done, 0);
    chk("idle_busy", Busy, 0);
  endtask

  initial begin
    Reset = 1'b1;
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    repeat (2) @(negedge Clk);
    #1 chk("reset_outputs", {ClearA, Add, Sub, Shift, Busy, Done, Clr_Ld}, 0);
    chk("reset_step", Step, 0);
    ClearA_LoadB = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      #1 chk("no_start_after_reset", {ClearA, Busy}, 0);
    end
    Run = 1'b0;
    @(negedge Clk);

    run_mult(8'h07, 1'b0, 1'b0, 1'b0);
    run_mult(8'h80, 1'b1, 1'b0, 1'b0);
    run_mult(8'hFF, 1'b0, 1'b0, 1'b1);
    run_mult(8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      run_mult(N'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    run_mult(8'hFF, 1'b0, 1'b1, 1'b0);
    run_mult(8'h3C, 1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge Clk);
    chk("queues_drained", exp_q.size() + done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
Name: mult_ctrl

Overview:
- Control unit for the 8-bit add/shift multiplier datapath (XA:B registers, 9-bit adder).
- Sequences one clear phase followed by NUM_BITS add/shift iterations per multiply.
- Takes B's LSB (M) from the datapath and drives the clear, load, add, subtract and shift strobes.
- Owns the iteration count, replacing the standalone 16-state counter in the datapath.

Parameters:
- NUM_BITS, 8, number of multiplier bits, which is also the iteration count; legal values 2..16.
- CW, $clog2(NUM_BITS), width of the Step output; derived, never overridden.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high; reset Reset, synchronous, active-high; clock Clk
- Run  in  1  level input, debounced upstream; a rising edge starts a multiply
- ClearA_LoadB  in  1  level input; request to clear XA and load B from switches
- M  in  1  current LSB of register B
- Clr_Ld  out  1  clear XA and load B, one-cycle enable to datapath
- ClearA  out  1  clear XA only (start of multiply)
- Add  out  1  load XA with XA+S
- Sub  out  1  load XA with XA-S (final iteration only)
- Shift  out  1  arithmetic right shift of X:A:B
- Busy  out  1  high from CLR through the final SHIFT, inclusive
- Done  out  1  high while in DONE
- Step  out  CW  current iteration index, 0..NUM_BITS-1

Behaviour:
- States: IDLE, CLR, ADD, SHIFT, DONE.
- Run_q: register holding Run from the previous cycle. start = Run & ~Run_q.
- Reset:
  - state=IDLE, Step=0, Run_q=1. Run therefore must be seen low before the first start.
  - All strobes, Busy and Done read 0 while Reset is high.
  - Reset mid-operation aborts the sequence at the next edge with no further strobes. Datapath contents are left as-is.
- Transitions:
  - IDLE: on start -> CLR; otherwise stay in IDLE.
  - CLR: ClearA=1 for exactly one cycle; Step<=0; -> ADD.
  - ADD:
    - Step < NUM_BITS-1: Add = M.
    - Step = NUM_BITS-1: Sub = M.
    - Add and Sub are never both high. -> SHIFT.
  - SHIFT: Shift=1.
    - Step = NUM_BITS-1 -> DONE, Step holds.
    - Otherwise Step<=Step+1 -> ADD.
  - DONE: Done=1. Run low -> IDLE; Run high -> stay in DONE. No auto-restart while Run is held.
- Clr_Ld = ClearA_LoadB & (state==IDLE | state==DONE).
  - Combinational; stays high for as long as the input is held.
  - Ignored while Busy. Not latched for later.
- Priority: if start and ClearA_LoadB are both high in IDLE, Clr_Ld is asserted that cycle and the next state is still CLR.
- A Run edge while Busy is ignored and not queued.
- Add, Sub, ClearA and Shift are decoded from state (plus M); they are not registered.
- Latency without the optional feature:
  - Start sampled at edge k puts CLR in cycle k+1.
  - DONE is entered at edge k+1+2*NUM_BITS, which is k+17 for NUM_BITS=8.
  - Exactly NUM_BITS Shift pulses occur per multiply.
- Step never wraps: the SHIFT-from-last-iteration exit is taken before any increment.

Optional Feature:
- Macro: MULT_CTRL_SKIP_ADD_EN.
- Defined:
  - In SHIFT, when not on the last iteration, the next state is ADD only if the M value presented for the next iteration is 1. Otherwise SHIFT is re-entered directly with Step+1.
  - From CLR, M=0 goes directly to SHIFT.
  - Each zero bit saves one cycle; latency is 1+NUM_BITS+(number of ones in B).
- Undefined: ADD is always visited, with Add/Sub gated by M; latency is fixed.
- Either way, the strobe sequence seen by the datapath is functionally identical apart from the removed idle ADD cycles.

Test Plan:
- Reset held 2 cycles with Run=1, then released -> no ClearA. Drop Run, raise it at edge k -> ClearA pulse in cycle k+1, Busy=1.
- B=0x07 (M stream 1,1,1,0,0,0,0,0), macro off -> Add high in ADD cycles of Step 0,1,2 only, Sub never, 8 Shift pulses, Done at edge k+17.
- B=0x80 (M stream 0×7 then 1), macro off -> Sub=1 only at Step=7, Add never, Done at edge k+17.
- Run held high after Done -> stays in DONE, Done=1. Release then re-raise -> new sequence, ClearA pulse. A Run toggle mid-sequence is ignored.
- ClearA_LoadB=1 in IDLE -> Clr_Ld=1 the same cycle. ClearA_LoadB=1 with Busy=1 -> Clr_Ld=0.
- Macro on, B=0x00 -> zero Add/Sub, Done at edge k+9. B=0xFF -> Done at edge k+17. Reset asserted at Step=3 -> IDLE next edge, all strobes 0.
